// File: rtl/fifo_level_if.sv
// Bus bundle for fifo_level: write/read handshake, status flags and occupancy.
// master drives push/pop/data_in/err_clr, slave (the FIFO) drives data and status back.
interface fifo_level_if #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 8
);
  localparam int unsigned LevelW = $clog2(Depth) + 1;

  logic [Width-1:0]  data_in;
  logic              push;
  logic              pop;
  logic              err_clr;
  logic [Width-1:0]  data_out;
  logic              full;
  logic              almost_full;
  logic              empty;
  logic              almost_empty;
  logic [LevelW-1:0] level;
  logic              overflow;
  logic              underflow;

  modport master (
    output data_in, push, pop, err_clr,
    input  data_out, full, almost_full, empty, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  data_in, push, pop, err_clr,
    output data_out, full, almost_full, empty, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/fifo_level.sv
// Single-clock full-depth FIFO with occupancy count and almost-full/empty thresholds.
// Define FIFO_LEVEL_ERR_EN to build the sticky overflow/underflow flags cleared by err_clr.
module fifo_level #(
  parameter int unsigned Width        = 32,
  parameter int unsigned Depth        = 8,
  parameter int unsigned AFullThresh  = Depth - 2,
  parameter int unsigned AEmptyThresh = 2
) (
  input logic          clk,
  input logic          reset,
  fifo_level_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(Depth);

  typedef logic [PtrW:0] cnt_t;

  localparam cnt_t DepthLvl  = cnt_t'(Depth);
  localparam cnt_t AFullLvl  = cnt_t'(AFullThresh);
  localparam cnt_t AEmptyLvl = cnt_t'(AEmptyThresh);

  cnt_t             wcnt_q, wcnt_d;
  cnt_t             rcnt_q, rcnt_d;
  cnt_t             level;
  logic [PtrW-1:0]  wptr, rptr;
  logic             push_acc, pop_acc;
  logic             full, empty;
  logic [Width-1:0] mem_q [Depth];

  // Extra lap bit lets level reach Depth without ambiguity against empty.
  assign level = wcnt_q - rcnt_q;
  assign wptr  = wcnt_q[PtrW-1:0];
  assign rptr  = rcnt_q[PtrW-1:0];
  assign empty = (level == '0);
  assign full  = (level == DepthLvl);

  assign pop_acc  = bus.pop && !empty;
  assign push_acc = bus.push && (!full || bus.pop);

  always_comb begin
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    if (push_acc) wcnt_d = wcnt_q + cnt_t'(1);
    if (pop_acc)  rcnt_d = rcnt_q + cnt_t'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
    end
  end

  // Storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (push_acc && !reset) begin
      mem_q[wptr] <= bus.data_in;
    end
  end

  assign bus.data_out     = mem_q[rptr];
  assign bus.level        = level;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_full  = (level >= AFullLvl);
  assign bus.almost_empty = (level <= AEmptyLvl);

`ifdef FIFO_LEVEL_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // A clear wins over a rejection in the same cycle.
  always_comb begin
    ovf_d = ovf_q | (bus.push && !push_acc);
    unf_d = unf_q | (bus.pop && !pop_acc);
    if (bus.err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_level.sv
// Directed bench for fifo_level: queue-based reference model compared every cycle,
// plus hand-computed expectations along the fill/drain/error/wrap scenarios.
module tb_fifo_level;

  localparam int unsigned Width = 32;
  localparam int unsigned Depth = 8;
  localparam int unsigned AFull = 6;
  localparam int unsigned AEmpt = 2;

`ifdef FIFO_LEVEL_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk;
  logic reset;
  bit   chk_en;
  int   n_vec;
  int   n_err;

  fifo_level_if #(.Width(Width), .Depth(Depth)) bus ();

  fifo_level #(
    .Width       (Width),
    .Depth       (Depth),
    .AFullThresh (AFull),
    .AEmptyThresh(AEmpt)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: an ordered queue plus sticky error bits.
  logic [Width-1:0] m_q[$];
  bit               m_ovf;
  bit               m_unf;

  always @(posedge clk) begin
    bit pu;
    bit po;
    if (reset) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      po = bus.pop && (m_q.size() > 0);
      pu = bus.push && ((m_q.size() < Depth) || bus.pop);
      if (ErrEn) begin
        if (bus.err_clr) begin
          m_ovf = 1'b0;
          m_unf = 1'b0;
        end else begin
          if (bus.push && !pu) m_ovf = 1'b1;
          if (bus.pop && !po)  m_unf = 1'b1;
        end
      end
      if (po) void'(m_q.pop_front());
      if (pu) m_q.push_back(bus.data_in);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("level",        32'(bus.level),        32'(m_q.size()));
      check("empty",        32'(bus.empty),        32'(m_q.size() == 0));
      check("full",         32'(bus.full),         32'(m_q.size() == Depth));
      check("almost_full",  32'(bus.almost_full),  32'(m_q.size() >= AFull));
      check("almost_empty", 32'(bus.almost_empty), 32'(m_q.size() <= AEmpt));
      check("overflow",     32'(bus.overflow),     32'(m_ovf));
      check("underflow",    32'(bus.underflow),    32'(m_unf));
      if (m_q.size() > 0) check("data_out", bus.data_out, m_q[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit pu, input bit po, input logic [31:0] d, input bit clr);
    bus.push    = pu;
    bus.pop     = po;
    bus.data_in = d;
    bus.err_clr = clr;
    tick();
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    chk_en      = 1'b0;
    reset       = 1'b1;
    bus.push    = 1'b1;
    bus.pop     = 1'b0;
    bus.data_in = 32'hDEAD_BEEF;
    bus.err_clr = 1'b0;
    repeat (2) tick();
    chk_en = 1'b1;
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_aempty", 32'(bus.almost_empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_afull", 32'(bus.almost_full), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    reset    = 1'b0;
    bus.push = 1'b0;

    // Fill and drain.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 32'h10 + 32'(i), 1'b0);
      if (i == 4) check("afull_after5", 32'(bus.almost_full), 32'd0);
      if (i == 5) check("afull_after6", 32'(bus.almost_full), 32'd1);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_level", 32'(bus.level), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("drain_data", bus.data_out, 32'h10 + 32'(i));
      drive(1'b0, 1'b1, 32'h0, 1'b0);
      if (i == 4) check("aempty_lvl3", 32'(bus.almost_empty), 32'd0);
      if (i == 5) check("aempty_lvl2", 32'(bus.almost_empty), 32'd1);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("drain_empty", 32'(bus.empty), 32'd1);

    // Push+pop at full.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 32'h20 + 32'(i), 1'b0);
    drive(1'b1, 1'b1, 32'hAA, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("pp_full_level", 32'(bus.level), 32'd8);
    check("pp_full_head", bus.data_out, 32'h21);
    check("pp_full_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("pp_full_drain", bus.data_out, (i == 7) ? 32'hAA : 32'h21 + 32'(i));
      drive(1'b0, 1'b1, 32'h0, 1'b0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    // Overflow: push at full, flag sticky until err_clr.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 32'h30 + 32'(i), 1'b0);
    drive(1'b1, 1'b0, 32'h99, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("ovf_level", 32'(bus.level), 32'd8);
    check("ovf_set", 32'(bus.overflow), 32'(ErrEn));
    repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("ovf_hold", 32'(bus.overflow), 32'(ErrEn));
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("ovf_clr", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain", bus.data_out, 32'h30 + 32'(i));
      drive(1'b0, 1'b1, 32'h0, 1'b0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    // Underflow, then clear beating a same-cycle rejected pop.
    drive(1'b0, 1'b1, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("unf_set", 32'(bus.underflow), 32'(ErrEn));
    check("unf_level", 32'(bus.level), 32'd0);
    drive(1'b0, 1'b1, 32'h0, 1'b1);
    check("clr_priority", 32'(bus.underflow), 32'd0);

    // Push+pop at empty.
    drive(1'b1, 1'b1, 32'h55, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("pp_empty_level", 32'(bus.level), 32'd1);
    check("pp_empty_data", bus.data_out, 32'h55);
    check("pp_empty_unf", 32'(bus.underflow), 32'(ErrEn));
    drive(1'b0, 1'b1, 32'h0, 1'b1);

    // Interleaved traffic carrying the counters through several wraps.
    for (int i = 0; i < 48; i++) begin
      drive((i % 6) != 5, (i % 4) != 3 && i > 2, 32'h100 + 32'(i), 1'b0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset mid-operation discards contents.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'h70 + 32'(i), 1'b0);
    reset = 1'b1;
    drive(1'b1, 1'b1, 32'h77, 1'b0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("midrst_level", 32'(bus.level), 32'd0);
    check("midrst_empty", 32'(bus.empty), 32'd1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
